// File: rtl/fwd_hazard_if.sv
// Pipeline hazard bus: decode/EX/MEM/WB register indices in, bypass selects and stall controls out.
interface fwd_hazard_if #(
    parameter int NSRC = 2,
    parameter int REGW = 5,
    parameter int SCW  = 16
);
    logic [NSRC*REGW-1:0] rs_d;
    logic [NSRC-1:0]      rs_used_d;
    logic [NSRC*REGW-1:0] rs_e;
    logic [REGW-1:0]      rd_e;
    logic [REGW-1:0]      rd_m;
    logic [REGW-1:0]      rd_w;
    logic                 regwrite_e;
    logic                 regwrite_m;
    logic                 regwrite_w;
    logic                 load_e;
    logic                 md_issue;
    logic [REGW-1:0]      md_rd;
    logic                 md_d;
    logic                 clr_stats;
    logic [NSRC*2-1:0]    fwd_sel;
    logic                 stall_f;
    logic                 stall_d;
    logic                 flush_e;
    logic                 md_busy;
    logic [SCW-1:0]       stall_cnt;

    modport master (
        output rs_d, rs_used_d, rs_e, rd_e, rd_m, rd_w,
        output regwrite_e, regwrite_m, regwrite_w, load_e,
        output md_issue, md_rd, md_d, clr_stats,
        input  fwd_sel, stall_f, stall_d, flush_e, md_busy, stall_cnt
    );

    modport slave (
        input  rs_d, rs_used_d, rs_e, rd_e, rd_m, rd_w,
        input  regwrite_e, regwrite_m, regwrite_w, load_e,
        input  md_issue, md_rd, md_d, clr_stats,
        output fwd_sel, stall_f, stall_d, flush_e, md_busy, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-detection unit: EX-operand bypass selects, load-use/RAW/multi-cycle stalls,
// a single-entry mul/div result scoreboard and a saturating stall counter.
module fwd_hazard_unit #(
    parameter int NSRC   = 2,
    parameter int REGW   = 5,
    parameter int MDLAT  = 4,
    parameter int FWD_EN = 1,
    parameter int SCW    = 16
) (
    input logic         clk,
    input logic         rst_n,
    fwd_hazard_if.slave bus
);
    localparam logic [REGW-1:0] X0     = {REGW{1'b0}};
    localparam logic [3:0]      MD_LAT = 4'(MDLAT);
    localparam logic [SCW-1:0]  CNT_MAX = {SCW{1'b1}};

    logic              md_busy_r;
    logic [3:0]        md_cnt_r;
    logic [REGW-1:0]   md_rdq_r;
    logic [SCW-1:0]    stall_cnt_r;
    logic [NSRC*2-1:0] fwd_sel_s;
    logic              md_pend_s;
    logic              load_use_s;
    logic              raw_s;
    logic              md_data_s;
    logic              md_struct_s;
    logic              stall_s;

    // x0 is hardwired zero, so a match on index 0 is never a real dependency.
    function automatic logic src_hit(input logic [REGW-1:0] rs, input logic [REGW-1:0] rd,
                                     input logic we);
        return we && (rs != X0) && (rs == rd);
    endfunction

    // Bypass select per EX operand; MEM is younger than WB so it wins.
    always_comb begin
        fwd_sel_s = {(NSRC*2){1'b0}};
        for (int i = 0; i < NSRC; i++) begin
            if (FWD_EN == 32'sd0) begin
                fwd_sel_s[2*i +: 2] = 2'b00;
            end else if (src_hit(bus.rs_e[i*REGW +: REGW], bus.rd_m, bus.regwrite_m)) begin
                fwd_sel_s[2*i +: 2] = 2'b10;
            end else if (src_hit(bus.rs_e[i*REGW +: REGW], bus.rd_w, bus.regwrite_w)) begin
                fwd_sel_s[2*i +: 2] = 2'b01;
            end else begin
                fwd_sel_s[2*i +: 2] = 2'b00;
            end
        end
    end

    // Stall sources; WB is write-first into the regfile so rd_w never stalls decode.
    always_comb begin
        md_pend_s  = md_busy_r && (md_cnt_r > 4'd1);
        load_use_s = 1'b0;
        raw_s      = 1'b0;
        md_data_s  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            load_use_s = load_use_s | (bus.rs_used_d[i] & bus.load_e &
                         src_hit(bus.rs_d[i*REGW +: REGW], bus.rd_e, bus.regwrite_e));
            raw_s      = raw_s | (bus.rs_used_d[i] & (FWD_EN == 32'sd0) &
                         (src_hit(bus.rs_d[i*REGW +: REGW], bus.rd_e, bus.regwrite_e) |
                          src_hit(bus.rs_d[i*REGW +: REGW], bus.rd_m, bus.regwrite_m)));
            md_data_s  = md_data_s | (bus.rs_used_d[i] &
                         src_hit(bus.rs_d[i*REGW +: REGW], md_rdq_r, md_pend_s));
        end
        md_struct_s = bus.md_d && md_pend_s;
        stall_s     = load_use_s | raw_s | md_data_s | md_struct_s;
    end

    // MD scoreboard: a new issue reloads even on the completion cycle; md_cnt==1 means result is in WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            md_busy_r <= 1'b0;
            md_cnt_r  <= 4'd0;
            md_rdq_r  <= X0;
        end else if (bus.md_issue && (bus.md_rd != X0)) begin
            md_busy_r <= 1'b1;
            md_cnt_r  <= MD_LAT;
            md_rdq_r  <= bus.md_rd;
        end else if (md_pend_s) begin
            md_cnt_r  <= md_cnt_r - 4'd1;
        end else if (md_busy_r) begin
            md_busy_r <= 1'b0;
            md_cnt_r  <= 4'd0;
        end else begin
            md_busy_r <= md_busy_r;
        end
    end

    // Saturating stall-cycle counter with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_r <= {SCW{1'b0}};
        end else if (bus.clr_stats) begin
            stall_cnt_r <= {SCW{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + {{(SCW-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign bus.fwd_sel   = fwd_sel_s;
    assign bus.stall_f   = stall_s;
    assign bus.stall_d   = stall_s;
    assign bus.flush_e   = stall_s;
    assign bus.md_busy   = md_busy_r;
    assign bus.stall_cnt = stall_cnt_r;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: dut A forwards (SCW=16), dut B stalls on every RAW (SCW=4); shared stimulus.
module tb_fwd_hazard_unit;
    localparam int NSRC = 2;
    localparam int REGW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NSRC*REGW-1:0] rs_d, rs_e;
    logic [NSRC-1:0]      rs_used_d;
    logic [REGW-1:0]      rd_e, rd_m, rd_w, md_rd;
    logic                 regwrite_e, regwrite_m, regwrite_w, load_e, md_issue, md_d;
    logic                 clr_a, clr_b;

    fwd_hazard_if #(.NSRC(NSRC), .REGW(REGW), .SCW(16)) a ();
    fwd_hazard_if #(.NSRC(NSRC), .REGW(REGW), .SCW(4))  b ();

    fwd_hazard_unit #(.NSRC(NSRC), .REGW(REGW), .MDLAT(4), .FWD_EN(1), .SCW(16))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(a));
    fwd_hazard_unit #(.NSRC(NSRC), .REGW(REGW), .MDLAT(4), .FWD_EN(0), .SCW(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(b));

    assign a.rs_d = rs_d;             assign b.rs_d = rs_d;
    assign a.rs_used_d = rs_used_d;   assign b.rs_used_d = rs_used_d;
    assign a.rs_e = rs_e;             assign b.rs_e = rs_e;
    assign a.rd_e = rd_e;             assign b.rd_e = rd_e;
    assign a.rd_m = rd_m;             assign b.rd_m = rd_m;
    assign a.rd_w = rd_w;             assign b.rd_w = rd_w;
    assign a.regwrite_e = regwrite_e; assign b.regwrite_e = regwrite_e;
    assign a.regwrite_m = regwrite_m; assign b.regwrite_m = regwrite_m;
    assign a.regwrite_w = regwrite_w; assign b.regwrite_w = regwrite_w;
    assign a.load_e = load_e;         assign b.load_e = load_e;
    assign a.md_issue = md_issue;     assign b.md_issue = md_issue;
    assign a.md_rd = md_rd;           assign b.md_rd = md_rd;
    assign a.md_d = md_d;             assign b.md_d = md_d;
    assign a.clr_stats = clr_a;       assign b.clr_stats = clr_b;

    typedef struct {
        string       name;
        int          dut;
        int          fld;
        logic [31:0] exp;
    } exp_t;

    localparam int F_FWD = 0, F_STALL = 1, F_BUSY = 2, F_CNT = 3;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(input string n, input int d, input int f, input logic [31:0] v);
        exp_t e;
        e.name = n; e.dut = d; e.fld = f; e.exp = v;
        q.push_back(e);
    endtask

    task automatic push_stall(input string n, input int d, input logic s);
        push(n, d, F_STALL, {29'd0, s, s, s});
    endtask

    function automatic logic [31:0] actual(input int d, input int f);
        logic [31:0] r;
        case (f)
            F_FWD:   r = (d == 0) ? {28'd0, a.fwd_sel} : {28'd0, b.fwd_sel};
            F_STALL: r = (d == 0) ? {29'd0, a.stall_f, a.stall_d, a.flush_e}
                                  : {29'd0, b.stall_f, b.stall_d, b.flush_e};
            F_BUSY:  r = (d == 0) ? {31'd0, a.md_busy} : {31'd0, b.md_busy};
            F_CNT:   r = (d == 0) ? {16'd0, a.stall_cnt} : {28'd0, b.stall_cnt};
            default: r = 32'hdead_beef;
        endcase
        return r;
    endfunction

    // Monitor: outputs are sampled on the falling edge, away from the register updates.
    exp_t        mon_e;
    logic [31:0] mon_act;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_act = actual(mon_e.dut, mon_e.fld);
            total++;
            if (mon_act !== mon_e.exp) begin
                bad++;
                $display("FAIL %s (dut %0d): got %0h expected %0h", mon_e.name, mon_e.dut,
                         mon_act, mon_e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs_d = 10'd0; rs_used_d = 2'b00; rs_e = 10'd0;
        rd_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        regwrite_e = 1'b0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        load_e = 1'b0; md_issue = 1'b0; md_rd = 5'd0; md_d = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        idle();
        step(); step();
        push("rst_busy", 0, F_BUSY, 32'd0);
        push("rst_cnt_a", 0, F_CNT, 32'd0);
        push("rst_cnt_b", 1, F_CNT, 32'd0);
        push_stall("rst_stall", 0, 1'b0);
        push("rst_fwd", 0, F_FWD, 32'd0);
        rst_n = 1'b1;

        // Forwarding priority and x0
        step(); idle();
        rs_e = {5'd0, 5'd5}; rd_m = 5'd5; rd_w = 5'd5; regwrite_m = 1'b1; regwrite_w = 1'b1;
        push("fwd_mem", 0, F_FWD, 32'h2);
        push("fwd_off", 1, F_FWD, 32'h0);
        step();
        regwrite_m = 1'b0;
        push("fwd_wb", 0, F_FWD, 32'h1);
        step();
        rs_e = {5'd5, 5'd0}; regwrite_m = 1'b1;
        push("fwd_op1_x0_op0", 0, F_FWD, 32'h8);

        // Load-use
        step(); idle();
        load_e = 1'b1; regwrite_e = 1'b1; rd_e = 5'd7; rs_d = {5'd7, 5'd0}; rs_used_d = 2'b10;
        push_stall("load_use", 0, 1'b1);
        push("cnt_before_lu", 0, F_CNT, 32'd0);
        step();
        rs_used_d = 2'b01;
        push_stall("load_unused", 0, 1'b0);
        push("cnt_after_lu", 0, F_CNT, 32'd1);

        // MD data hazard, MDLAT=4
        step(); idle();
        md_issue = 1'b1; md_rd = 5'd9; rs_d = {5'd0, 5'd9}; rs_used_d = 2'b01;
        push_stall("md_issue_cyc", 0, 1'b0);
        push("md_idle_busy", 0, F_BUSY, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            md_issue = 1'b0;
            push_stall("md_data", 0, 1'b1);
            push("md_busy", 0, F_BUSY, 32'd1);
        end
        step();
        push_stall("md_cnt1_nostall", 0, 1'b0);
        push("md_cnt1_busy", 0, F_BUSY, 32'd1);
        step();
        rd_w = 5'd9; regwrite_w = 1'b1;
        push("md_done", 0, F_BUSY, 32'd0);
        push_stall("md_done_stall", 0, 1'b0);
        push_stall("wb_write_first", 1, 1'b0);
        push("cnt_after_md", 0, F_CNT, 32'd4);

        // Completion coinciding with a new issue
        step(); idle();
        md_issue = 1'b1; md_rd = 5'd9;
        for (int k = 0; k < 4; k++) begin
            step(); idle();
        end
        md_issue = 1'b1; md_rd = 5'd3; md_d = 1'b1;
        push("reissue_busy", 0, F_BUSY, 32'd1);
        push_stall("struct_cnt1", 0, 1'b0);
        step(); idle();
        md_d = 1'b1;
        push_stall("struct_stall", 0, 1'b1);
        push("reload_busy", 0, F_BUSY, 32'd1);
        step(); idle();
        rs_d = {5'd0, 5'd3}; rs_used_d = 2'b01;
        push_stall("rdq_new", 0, 1'b1);
        step(); idle();
        rs_d = {5'd0, 5'd9}; rs_used_d = 2'b01;
        push_stall("rdq_old", 0, 1'b0);
        push("cnt_after_reload", 0, F_CNT, 32'd6);

        // Reset mid MD operation
        step(); idle();
        md_issue = 1'b1; md_rd = 5'd3;
        step(); idle();
        step(); idle();
        rst_n = 1'b0; rs_d = {5'd0, 5'd3}; rs_used_d = 2'b01;
        push_stall("rst_comb_stall", 0, 1'b1);
        step(); idle();
        rst_n = 1'b1; rs_d = {5'd0, 5'd3}; rs_used_d = 2'b01; md_d = 1'b1;
        push_stall("post_rst_stall", 0, 1'b0);
        push("post_rst_busy", 0, F_BUSY, 32'd0);
        push("post_rst_cnt_a", 0, F_CNT, 32'd0);
        push("post_rst_cnt_b", 1, F_CNT, 32'd0);

        // No-forwarding RAW stall and counter saturation
        for (int k = 0; k < 20; k++) begin
            step(); idle();
            rd_m = 5'd4; regwrite_m = 1'b1; rs_d = {5'd0, 5'd4}; rs_used_d = 2'b01; rs_e = {5'd0, 5'd4};
            push_stall("raw_stall_b", 1, 1'b1);
            push("raw_fwd_b", 1, F_FWD, 32'h0);
            push_stall("raw_nostall_a", 0, 1'b0);
            push("raw_fwd_a", 0, F_FWD, 32'h2);
            push("sat_cnt_b", 1, F_CNT, (k < 15) ? k : 15);
        end
        step(); idle();
        rd_m = 5'd4; regwrite_m = 1'b1; rs_d = {5'd0, 5'd4}; rs_used_d = 2'b01;
        clr_b = 1'b1;
        push("sat_hold_b", 1, F_CNT, 32'd15);
        step(); idle();
        clr_b = 1'b0;
        push("clr_cnt_b", 1, F_CNT, 32'd0);
        step(); idle();
        rd_e = 5'd6; regwrite_e = 1'b1; rs_d = {5'd6, 5'd0}; rs_used_d = 2'b10;
        push("clr_held_b", 1, F_CNT, 32'd0);
        push_stall("raw_ex_b", 1, 1'b1);
        push_stall("raw_ex_a", 0, 1'b0);
        push("cnt_a_quiet", 0, F_CNT, 32'd0);

        // x0 never hazards, forwards or gets scoreboarded
        step(); idle();
        rd_e = 5'd0; regwrite_e = 1'b1; load_e = 1'b1; rd_m = 5'd0; regwrite_m = 1'b1;
        rd_w = 5'd0; regwrite_w = 1'b1; rs_used_d = 2'b11; md_issue = 1'b1; md_rd = 5'd0;
        push_stall("x0_stall_b", 1, 1'b0);
        push_stall("x0_stall_a", 0, 1'b0);
        push("x0_fwd", 0, F_FWD, 32'h0);
        push("cnt_b_one", 1, F_CNT, 32'd1);
        step(); idle();
        push("x0_md_busy", 0, F_BUSY, 32'd0);

        step(); step();
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d pending expectations, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter NSRC, default 2: number of EX/ID source operands handled (1..4).
REQ-002 Parameter REGW, default 5: register index width.
REQ-003 Parameter MDLAT, default 4: fixed multi-cycle (mul/div) latency in cycles from EX issue to W write (2..15).
REQ-004 Parameter FWD_EN, default 1: 1 = bypass forwarding; 0 = no forwarding, resolve every RAW by stalling.
REQ-005 Parameter SCW, default 16: stall statistics counter width.
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 rs_d  in  NSRC*REGW  decode-stage source indices, operand i at bits [i*REGW +: REGW].
REQ-009 rs_used_d  in  NSRC  per-operand "source actually read" mask for decode.
REQ-010 rs_e  in  NSRC*REGW  EX-stage source indices, same packing.
REQ-011 rd_e, rd_m, rd_w  in  REGW each  destination indices in EX, MEM, WB.
REQ-012 regwrite_e, regwrite_m, regwrite_w  in  1 each  destination-write enables.
REQ-013 load_e  in  1  EX holds a load.
REQ-014 md_issue  in  1  MD op leaves EX this cycle (only meaningful when stall_d=0); md_rd  in  REGW  its destination.
REQ-015 md_d  in  1  decode holds an MD op.
REQ-016 clr_stats  in  1  synchronous clear of stall counter.
REQ-017 fwd_sel  out  NSRC*2  per-operand select: 00 regfile, 10 MEM result, 01 WB result.
REQ-018 stall_f, stall_d, flush_e  out  1 each  hold PC, hold IF/ID, bubble into ID/EX.
REQ-019 md_busy  out  1  MD result outstanding; stall_cnt  out  SCW  cycles stalled.

Function
REQ-020 Forwarding, per operand i: 10 if rs_e[i]!=0 & rs_e[i]==rd_m & regwrite_m; else 01 if rs_e[i]!=0 & rs_e[i]==rd_w & regwrite_w; else 00; MEM has priority over WB.
REQ-021 With FWD_EN=0, fwd_sel SHALL be all zeros regardless of inputs.
REQ-022 Regfile is write-first within a cycle; a source matching rd_w in decode never causes a stall.
REQ-023 Load-use hazard: load_e & regwrite_e & rd_e!=0 & any i with rs_used_d[i] & rs_d[i]==rd_e.
REQ-024 FWD_EN=0 RAW hazard: any used rs_d[i]!=0 matching rd_e (with regwrite_e) or rd_m (with regwrite_m).
REQ-025 MD scoreboard state: md_busy, md_cnt (4 bits), md_rdq (REGW bits).
REQ-026 On edge with md_issue=1 & md_rd!=0: md_busy<=1, md_cnt<=MDLAT, md_rdq<=md_rd.
REQ-027 md_issue with md_rd==0: scoreboard not loaded (result discarded, no hazard).
REQ-028 Else if md_busy & md_cnt>1: md_cnt<=md_cnt-1; if md_busy & md_cnt==1: md_busy<=0 (result in WB that cycle).
REQ-029 Simultaneous completion (md_cnt==1) and new md_issue: new issue wins, reload per REQ-026.
REQ-030 MD data hazard: md_busy & md_cnt>1 & any used rs_d[i]!=0 equal to md_rdq.
REQ-031 MD structural hazard: md_d & md_busy & md_cnt>1.
REQ-032 stall_d = stall_f = flush_e = OR of REQ-023, REQ-024 (FWD_EN=0 only), REQ-030, REQ-031; purely combinational from inputs and state.
REQ-033 stall_cnt increments by 1 on each edge where stall_d=1, saturates at all-ones, never wraps.
REQ-034 clr_stats=1 zeroes stall_cnt on that edge, overriding increment.
REQ-035 x0 (index 0) SHALL never forward, stall or be scoreboarded.

Reset
REQ-036 While rst_n=0 at an edge: md_busy<=0, md_cnt<=0, md_rdq<=0, stall_cnt<=0; reset overrides md_issue and clr_stats.
REQ-037 Reset mid-MD-operation abandons outstanding op; no stall from it on the following cycle.
REQ-038 Combinational outputs follow inputs during reset; stall terms from scoreboard are 0 once reset state is loaded.

Verification
REQ-039 rs_e[0]=5, rd_m=5, rd_w=5, regwrite_m=regwrite_w=1 -> fwd_sel[1:0]=10; regwrite_m=0 -> 01; rs_e[0]=0 -> 00.
REQ-040 load_e=1, regwrite_e=1, rd_e=7, rs_d[1]=7, rs_used_d=2'b10 -> stall_d=stall_f=flush_e=1, stall_cnt +1; rs_used_d=2'b01 -> no stall.
REQ-041 MDLAT=4, md_issue md_rd=9, then rs_d[0]=9 used every cycle -> stall 3 cycles (md_cnt 4,3,2), no stall at md_cnt=1, md_busy low after.
REQ-042 md_cnt==1 with md_issue md_rd=3 same edge -> md_busy stays 1, md_cnt=4, md_rdq=3; md_d=1 next cycle -> structural stall.
REQ-043 FWD_EN=0, rd_m=4, regwrite_m=1, rs_d[0]=4 used -> stall_d=1, fwd_sel=0; SCW=4 stall 20 cycles -> stall_cnt=15; clr_stats -> 0.
REQ-044 rst_n=0 one edge while md_busy=1, md_cnt=3 -> md_busy=0, stall_cnt=0, no MD stall next cycle.
